ram_frame_reader: RTL and testbench
===================================

# ram_frame_reader

Reads frames out of the shared 16 Kword x 16-bit dual-port frame RAM through its read-only port and serialises them as a GMII-style byte stream: preamble, SFD, payload, then inter-frame gap. The writer side fills the RAM through the other port and advertises progress with a word write pointer. This block is the drain end of that buffer: it owns the read pointer and hands freed space back to the writer.

## Interface
Parameters:
- ADDR_W, 14, word-address width of the frame RAM; pointers wrap modulo 2^ADDR_W
- MAX_LEN, 1518, largest legal payload length in bytes
- IFG, 12, idle cycles (TxEn=0) forced after each frame's last byte

Ports:
- Clock  in  1  single clock for the whole block and the RAM read port
- Reset  in  1  synchronous, active-high
- Enable  in  1  permits a new frame start; sampled only in IDLE
- WrPtr  in  ADDR_W  writer's next-free word address; advanced by the writer only after a complete frame is in RAM
- RdPtr  out  ADDR_W  address of the next unread frame header; free space = RdPtr - WrPtr - 1
- AddressB  out  ADDR_W  RAM read address
- ClockEnB  out  1  RAM read enable
- QB  in  16  RAM read data; valid one cycle after AddressB/ClockEnB
- TxEn  out  1  byte-valid on TxD
- TxD  out  8  transmitted byte
- FrameDone  out  1  one-cycle pulse with the last payload byte
- ErrFrame  out  1  one-cycle pulse when a bad header is found

## Operation
- RAM layout per frame:
  - header word H: bits[10:0] = payload length L in bytes; bits[15:11] are ignored
  - payload words H+1 .. H+ceil(L/2): byte 2i is in bits[7:0], byte 2i+1 in bits[15:8]
  - for odd L, the upper byte of the last word is unused
- Buffer is empty when RdPtr == WrPtr. All address arithmetic is modulo 2^ADDR_W, and wrap mid-frame is legal.
- States:
  - IDLE: if Enable && !empty, issue a read of RdPtr, then go to LEN.
  - LEN: latch L from QB.
    - If L==0 or L>MAX_LEN: pulse ErrFrame, set RdPtr<=WrPtr (flush), go to IDLE.
    - Otherwise issue a read of H+1 and go to PRE.
  - PRE: 8 cycles driving 0x55 x7 then 0xD5. Word H+1 is captured in a 16-bit holding register during PRE.
  - DATA: one byte per cycle.
    - On each even byte, drive the low half of the holding register and issue the read of the next word (only if one remains).
    - On each odd byte, drive the high half; the next word has arrived and is loaded into the holding register.
    - On the last byte: pulse FrameDone, set RdPtr <= H+1+ceil(L/2), go to IFG.
  - IFG: IFG cycles with TxEn=0, then IDLE.
- RdPtr commits only at frame end, so the writer never overwrites a frame that is being sent.
- Enable deasserting mid-frame has no effect; the current frame completes.
- WrPtr changes mid-frame are ignored except for the empty test in IDLE and the flush in LEN.
- The block never writes RAM. The integrator ties the port's write enable and byte enables low.

## Timing
- Reset values: RdPtr=0, AddressB=0, ClockEnB=0, TxEn=0, TxD=0x00, FrameDone=0, ErrFrame=0, state=IDLE, holding register=0.
- All outputs are registered.
- Start latency: header read issued at cycle t (IDLE), L checked at t+1, first preamble byte at t+2, first payload byte at t+10.
- Frame length on the wire: TxEn is high for exactly 8+L consecutive cycles, with no bubbles.
- Back-to-back frames: minimum TxEn-low gap is IFG+2 cycles.
- ErrFrame pulses at t+1; RdPtr equals the sampled WrPtr at t+2; TxEn never rises for that frame.
- Reset mid-frame: at the next edge TxEn=0 and all outputs take reset values; nothing is transmitted until Reset deasserts. Writer and reader are reset together.
- Max L=MAX_LEN; L=1 gives a 9-byte burst using one payload word.

## Structure
- Shared package (frame-buffer package also used by the writer):
  - state enum {IDLE, LEN, PRE, DATA, IFG}
  - PREAMBLE=8'h55, SFD=8'hD5
  - LEN_MSB=10 (header length field)
- No sub-module. One FSM plus a byte counter (11 bit), a preamble/IFG counter, the holding register and address/pointer registers.

## Test plan
- Empty buffer, Enable=1 for 100 cycles -> TxEn stays 0, ClockEnB pulses 0, RdPtr=0.
- Frame at 0, L=5, words 0x0005, 0x2211, 0x4433, 0xXX55, WrPtr=4 -> TxD = 55x7, D5, 11 22 33 44 55 over 13 cycles; FrameDone with 0x55; RdPtr=4.
- Two frames back-to-back (L=60, L=64) -> TxEn-low gap exactly IFG+2=14 cycles; RdPtr=31 then 64.
- Frame header at 16382 with L=6 (wraps) -> payload read from 16383, 0, 1; RdPtr=2; bytes correct.
- Header L=0 and header L=1600 at RdPtr=10, WrPtr=40 -> ErrFrame pulse, RdPtr=40, TxEn never high.
- Reset asserted at payload byte 20 of L=100 -> TxEn=0 next cycle, RdPtr=0; after release and Enable, the frame is resent from address 0 in full.

Source files
------------

// File: rtl/ram_frame_reader_pkg.sv
// Shared frame-buffer definitions used by both the RAM writer and the frame reader.
// Holds the reader state encoding, line symbols and the header length field layout.
package ram_frame_reader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LEN  = 3'd1,
    ST_PRE  = 3'd2,
    ST_DATA = 3'd3,
    ST_IFG  = 3'd4
  } state_t;

  localparam logic [7:0] PREAMBLE = 8'h55;
  localparam logic [7:0] SFD      = 8'hD5;
  localparam int         LEN_MSB  = 10;

  // Payload words occupied by a frame of len bytes (two bytes per word, rounded up).
  function automatic logic [LEN_MSB:0] words_for_len(input logic [LEN_MSB:0] len);
    logic [LEN_MSB+1:0] sum;
    sum = {1'b0, len} + 12'd1;
    return sum[LEN_MSB+1:1];
  endfunction

endpackage

// File: rtl/ram_frame_reader_if.sv
// Frame-buffer read side: writer pointer in, RAM read port, and the GMII-style byte stream.
interface ram_frame_reader_if #(
  parameter int ADDR_W = 14
);

  logic              Enable;
  logic [ADDR_W-1:0] WrPtr;
  logic [ADDR_W-1:0] RdPtr;
  logic [ADDR_W-1:0] AddressB;
  logic              ClockEnB;
  logic [15:0]       QB;
  logic              TxEn;
  logic [7:0]        TxD;
  logic              FrameDone;
  logic              ErrFrame;

  modport master (
    input  Enable, WrPtr, QB,
    output RdPtr, AddressB, ClockEnB, TxEn, TxD, FrameDone, ErrFrame
  );

  modport slave (
    output Enable, WrPtr, QB,
    input  RdPtr, AddressB, ClockEnB, TxEn, TxD, FrameDone, ErrFrame
  );

endinterface

// File: rtl/ram_frame_reader.sv
// Drains length-prefixed frames from the shared frame RAM and serialises them as
// preamble + SFD + payload bytes, returning consumed space by advancing RdPtr at frame end.
module ram_frame_reader
  import ram_frame_reader_pkg::*;
#(
  parameter int ADDR_W  = 14,
  parameter int MAX_LEN = 1518,
  parameter int IFG     = 12
) (
  input  logic                  Clock,
  input  logic                  Reset,
  ram_frame_reader_if.master    bus
);

  localparam int CNT_W = $clog2(IFG + 8) + 1;

  state_t              state_r;
  logic [LEN_MSB:0]    len_r;
  logic [LEN_MSB:0]    byte_r;
  logic [CNT_W-1:0]    cnt_r;
  logic [15:0]         hold_r;
  logic [ADDR_W-1:0]   hdr_r;
  logic [ADDR_W-1:0]   rd_ptr_r;
  logic [ADDR_W-1:0]   addr_r;
  logic                ce_r;
  logic                tx_en_r;
  logic [7:0]          txd_r;
  logic                done_r;
  logic                err_r;

  logic [LEN_MSB:0]    len_q_s;
  logic                len_bad_s;
  logic                empty_s;
  logic [15:0]         word_s;
  logic                more_s;
  logic                last_s;
  logic [ADDR_W-1:0]   next_rd_s;

  assign len_q_s   = bus.QB[LEN_MSB:0];
  assign len_bad_s = (len_q_s == 11'd0) || (len_q_s > 11'(MAX_LEN));
  assign empty_s   = (rd_ptr_r == bus.WrPtr);
  // The first payload word was parked in hold_r during the preamble; later words come straight off QB.
  assign word_s    = (byte_r == 11'd0) ? hold_r : bus.QB;
  assign more_s    = ({1'b0, byte_r} + 12'd2) < {1'b0, len_r};
  assign last_s    = (byte_r == (len_r - 11'd1));
  assign next_rd_s = hdr_r + ADDR_W'(1) + ADDR_W'(words_for_len(len_r));

  assign bus.RdPtr     = rd_ptr_r;
  assign bus.AddressB  = addr_r;
  assign bus.ClockEnB  = ce_r;
  assign bus.TxEn      = tx_en_r;
  assign bus.TxD       = txd_r;
  assign bus.FrameDone = done_r;
  assign bus.ErrFrame  = err_r;

  // Reader FSM with its counters, holding register and all registered outputs.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_r  <= ST_IDLE;
      len_r    <= 11'd0;
      byte_r   <= 11'd0;
      cnt_r    <= '0;
      hold_r   <= 16'h0000;
      hdr_r    <= '0;
      rd_ptr_r <= '0;
      addr_r   <= '0;
      ce_r     <= 1'b0;
      tx_en_r  <= 1'b0;
      txd_r    <= 8'h00;
      done_r   <= 1'b0;
      err_r    <= 1'b0;
    end else begin
      ce_r   <= 1'b0;
      done_r <= 1'b0;
      err_r  <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          tx_en_r <= 1'b0;
          cnt_r   <= '0;
          if (bus.Enable && !empty_s) begin
            addr_r  <= rd_ptr_r;
            hdr_r   <= rd_ptr_r;
            ce_r    <= 1'b1;
            state_r <= ST_LEN;
          end
        end
        // First LEN cycle waits for the RAM's registered read data.
        ST_LEN: begin
          if (cnt_r == CNT_W'(0)) begin
            cnt_r <= CNT_W'(1);
          end else if (len_bad_s) begin
            err_r    <= 1'b1;
            rd_ptr_r <= bus.WrPtr;
            state_r  <= ST_IDLE;
          end else begin
            len_r   <= len_q_s;
            addr_r  <= hdr_r + ADDR_W'(1);
            ce_r    <= 1'b1;
            tx_en_r <= 1'b1;
            txd_r   <= PREAMBLE;
            cnt_r   <= CNT_W'(1);
            state_r <= ST_PRE;
          end
        end
        ST_PRE: begin
          cnt_r <= cnt_r + CNT_W'(1);
          if (cnt_r == CNT_W'(2)) begin
            hold_r <= bus.QB;
          end
          if (cnt_r == CNT_W'(7)) begin
            txd_r   <= SFD;
            byte_r  <= 11'd0;
            state_r <= ST_DATA;
          end else begin
            txd_r <= PREAMBLE;
          end
        end
        // Even bytes prefetch the next word two cycles ahead of its first use.
        ST_DATA: begin
          if (!byte_r[0]) begin
            txd_r  <= word_s[7:0];
            hold_r <= word_s;
            if (more_s) begin
              addr_r <= addr_r + ADDR_W'(1);
              ce_r   <= 1'b1;
            end
          end else begin
            txd_r <= hold_r[15:8];
          end
          if (last_s) begin
            done_r   <= 1'b1;
            rd_ptr_r <= next_rd_s;
            cnt_r    <= '0;
            state_r  <= ST_IFG;
          end else begin
            byte_r <= byte_r + 11'd1;
          end
        end
        ST_IFG: begin
          tx_en_r <= 1'b0;
          txd_r   <= 8'h00;
          if (cnt_r == CNT_W'(IFG - 1)) begin
            state_r <= ST_IDLE;
          end else begin
            cnt_r <= cnt_r + CNT_W'(1);
          end
        end
        default: begin
          tx_en_r <= 1'b0;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ram_frame_reader.sv
// Directed bench for ram_frame_reader: behavioural frame RAM, byte-stream monitor and scenario tasks.
module tb_ram_frame_reader;
  import ram_frame_reader_pkg::*;

  localparam int ADDR_W  = 14;
  localparam int MAX_LEN = 1518;
  localparam int IFG     = 12;
  localparam int DEPTH   = 1 << ADDR_W;

  logic Clock = 1'b0;
  logic Reset;

  ram_frame_reader_if #(.ADDR_W(ADDR_W)) bus ();

  ram_frame_reader #(.ADDR_W(ADDR_W), .MAX_LEN(MAX_LEN), .IFG(IFG)) dut (
    .Clock (Clock),
    .Reset (Reset),
    .bus   (bus)
  );

  always #5 Clock = ~Clock;

  logic [15:0] mem [0:DEPTH-1];

  // Registered read port: data appears the cycle after the enabled address.
  always @(posedge Clock) begin
    if (bus.ClockEnB) bus.QB <= mem[bus.AddressB];
  end

  int chk_cnt = 0;
  int pass_cnt = 0;

  logic [7:0]        rx_q[$];
  logic [7:0]        exp_q[$];
  int                burst_q[$];
  int                gap_q[$];
  logic [7:0]        done_byte_q[$];
  logic [ADDR_W-1:0] rd_done_q[$];
  int burst_len, low_run, err_cnt, ce_cnt, done_cnt;
  bit any_high;

  initial begin
    forever begin
      @(negedge Clock);
      if (bus.TxEn === 1'b1) begin
        rx_q.push_back(bus.TxD);
        burst_len++;
        if (any_high && low_run > 0) gap_q.push_back(low_run);
        low_run  = 0;
        any_high = 1'b1;
      end else begin
        if (burst_len > 0) burst_q.push_back(burst_len);
        burst_len = 0;
        low_run++;
      end
      if (bus.FrameDone === 1'b1) begin
        done_cnt++;
        done_byte_q.push_back(bus.TxD);
        rd_done_q.push_back(bus.RdPtr);
      end
      if (bus.ErrFrame === 1'b1) err_cnt++;
      if (bus.ClockEnB === 1'b1) ce_cnt++;
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge Clock);
      #1;
    end
  endtask

  task automatic clear_mon();
    rx_q.delete(); burst_q.delete(); gap_q.delete();
    done_byte_q.delete(); rd_done_q.delete();
    burst_len = 0; low_run = 0; any_high = 1'b0;
    err_cnt = 0; ce_cnt = 0; done_cnt = 0;
  endtask

  task automatic do_reset();
    Reset = 1'b1; bus.Enable = 1'b0; bus.WrPtr = '0;
    step(3);
    Reset = 1'b0;
    clear_mon();
    exp_q.delete();
  endtask

  // Writes header + payload (byte j = base + stride*j) and appends the expected wire bytes.
  task automatic put_frame(input int hdr, input int len, input logic [7:0] base,
                           input logic [7:0] stride, input logic [15:0] hi_bits);
    int v;
    logic [7:0] lo, hi;
    mem[hdr % DEPTH] = hi_bits | 16'(len);
    for (int j = 0; j < len; j += 2) begin
      v  = int'(base) + int'(stride) * j;
      lo = 8'(v);
      v  = int'(base) + int'(stride) * (j + 1);
      hi = (j + 1 < len) ? 8'(v) : 8'hAB;
      mem[(hdr + 1 + j / 2) % DEPTH] = {hi, lo};
    end
    for (int k = 0; k < 7; k++) exp_q.push_back(PREAMBLE);
    exp_q.push_back(SFD);
    for (int j = 0; j < len; j++) begin
      v = int'(base) + int'(stride) * j;
      exp_q.push_back(8'(v));
    end
  endtask

  task automatic wait_done(input int target, input int budget);
    for (int i = 0; i < budget; i++) begin
      if (done_cnt >= target) break;
      step(1);
    end
  endtask

  task automatic test_reset();
    Reset = 1'b1; bus.Enable = 1'b0; bus.WrPtr = '0;
    step(2);
    chk_cnt++; if (bus.RdPtr !== 14'd0) $display("FAIL reset_rdptr: got %0d want 0", bus.RdPtr); else pass_cnt++;
    chk_cnt++; if (bus.AddressB !== 14'd0) $display("FAIL reset_addr: got %0d want 0", bus.AddressB); else pass_cnt++;
    chk_cnt++; if (bus.ClockEnB !== 1'b0) $display("FAIL reset_ce: got %b want 0", bus.ClockEnB); else pass_cnt++;
    chk_cnt++; if (bus.TxEn !== 1'b0) $display("FAIL reset_txen: got %b want 0", bus.TxEn); else pass_cnt++;
    chk_cnt++; if (bus.TxD !== 8'h00) $display("FAIL reset_txd: got %h want 00", bus.TxD); else pass_cnt++;
    chk_cnt++; if (bus.FrameDone !== 1'b0) $display("FAIL reset_done: got %b want 0", bus.FrameDone); else pass_cnt++;
    chk_cnt++; if (bus.ErrFrame !== 1'b0) $display("FAIL reset_err: got %b want 0", bus.ErrFrame); else pass_cnt++;
    Reset = 1'b0;
    step(1);
    clear_mon();
  endtask

  task automatic test_empty();
    bus.WrPtr = '0; bus.Enable = 1'b1;
    step(100);
    chk_cnt++; if (ce_cnt !== 0) $display("FAIL empty_ce: got %0d pulses want 0", ce_cnt); else pass_cnt++;
    chk_cnt++; if (rx_q.size() !== 0) $display("FAIL empty_txen: got %0d bytes want 0", rx_q.size()); else pass_cnt++;
    chk_cnt++; if (bus.RdPtr !== 14'd0) $display("FAIL empty_rdptr: got %0d want 0", bus.RdPtr); else pass_cnt++;
  endtask

  task automatic check_stream(input string name);
    chk_cnt++;
    if (rx_q.size() !== exp_q.size()) $display("FAIL %s_len: got %0d bytes want %0d", name, rx_q.size(), exp_q.size());
    else pass_cnt++;
    for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
      chk_cnt++;
      if (rx_q[i] !== exp_q[i]) $display("FAIL %s_byte%0d: got %h want %h", name, i, rx_q[i], exp_q[i]);
      else pass_cnt++;
    end
  endtask

  task automatic test_single();
    do_reset();
    put_frame(0, 5, 8'h11, 8'h11, 16'h0000);
    bus.WrPtr = 14'd4; bus.Enable = 1'b1;
    wait_done(1, 200);
    step(IFG + 4);
    chk_cnt++; if (done_cnt !== 1) $display("FAIL single_done: got %0d want 1", done_cnt); else pass_cnt++;
    check_stream("single");
    chk_cnt++; if ((burst_q.size() > 0 ? burst_q[0] : -1) !== 13) $display("FAIL single_burst: got %0d want 13", burst_q.size() > 0 ? burst_q[0] : -1); else pass_cnt++;
    chk_cnt++; if ((done_byte_q.size() > 0 ? done_byte_q[0] : 8'h00) !== 8'h55) $display("FAIL single_donebyte: got %h want 55", done_byte_q.size() > 0 ? done_byte_q[0] : 8'h00); else pass_cnt++;
    chk_cnt++; if (bus.RdPtr !== 14'd4) $display("FAIL single_rdptr: got %0d want 4", bus.RdPtr); else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    do_reset();
    put_frame(0, 60, 8'h01, 8'h01, 16'h0000);
    put_frame(31, 64, 8'hA0, 8'h03, 16'h0000);
    bus.WrPtr = 14'd64; bus.Enable = 1'b1;
    wait_done(2, 600);
    step(IFG + 4);
    chk_cnt++; if (done_cnt !== 2) $display("FAIL b2b_done: got %0d want 2", done_cnt); else pass_cnt++;
    check_stream("b2b");
    chk_cnt++; if ((burst_q.size() > 1 ? burst_q[1] : -1) !== 72) $display("FAIL b2b_burst2: got %0d want 72", burst_q.size() > 1 ? burst_q[1] : -1); else pass_cnt++;
    chk_cnt++; if ((gap_q.size() > 0 ? gap_q[0] : -1) !== IFG + 2) $display("FAIL b2b_gap: got %0d want %0d", gap_q.size() > 0 ? gap_q[0] : -1, IFG + 2); else pass_cnt++;
    chk_cnt++; if ((rd_done_q.size() > 0 ? rd_done_q[0] : 14'd0) !== 14'd31) $display("FAIL b2b_rdptr1: got %0d want 31", rd_done_q.size() > 0 ? rd_done_q[0] : 14'd0); else pass_cnt++;
    chk_cnt++; if (bus.RdPtr !== 14'd64) $display("FAIL b2b_rdptr2: got %0d want 64", bus.RdPtr); else pass_cnt++;
  endtask

  task automatic test_wrap();
    do_reset();
    mem[0] = 16'h0000;
    bus.WrPtr = 14'd16382; bus.Enable = 1'b1;
    step(20);
    chk_cnt++; if (err_cnt !== 1) $display("FAIL wrap_flush_err: got %0d want 1", err_cnt); else pass_cnt++;
    chk_cnt++; if (bus.RdPtr !== 14'd16382) $display("FAIL wrap_flush_rdptr: got %0d want 16382", bus.RdPtr); else pass_cnt++;
    put_frame(16382, 6, 8'h11, 8'h11, 16'h0000);
    bus.WrPtr = 14'd2;
    wait_done(1, 200);
    step(IFG + 4);
    chk_cnt++; if (done_cnt !== 1) $display("FAIL wrap_done: got %0d want 1", done_cnt); else pass_cnt++;
    check_stream("wrap");
    chk_cnt++; if (bus.RdPtr !== 14'd2) $display("FAIL wrap_rdptr: got %0d want 2", bus.RdPtr); else pass_cnt++;
  endtask

  task automatic test_bad_headers();
    do_reset();
    put_frame(0, 18, 8'h40, 8'h01, 16'h0000);
    mem[10] = 16'hF800;
    mem[40] = 16'h0640;
    mem[70] = 16'h05EF;
    bus.WrPtr = 14'd40; bus.Enable = 1'b1;
    wait_done(1, 200);
    step(30);
    chk_cnt++; if (err_cnt !== 1) $display("FAIL bad_len0_err: got %0d want 1", err_cnt); else pass_cnt++;
    chk_cnt++; if (bus.RdPtr !== 14'd40) $display("FAIL bad_len0_rdptr: got %0d want 40", bus.RdPtr); else pass_cnt++;
    bus.WrPtr = 14'd70;
    step(10);
    chk_cnt++; if (err_cnt !== 2) $display("FAIL bad_len1600_err: got %0d want 2", err_cnt); else pass_cnt++;
    chk_cnt++; if (bus.RdPtr !== 14'd70) $display("FAIL bad_len1600_rdptr: got %0d want 70", bus.RdPtr); else pass_cnt++;
    bus.WrPtr = 14'd100;
    step(10);
    chk_cnt++; if (err_cnt !== 3) $display("FAIL bad_len1519_err: got %0d want 3", err_cnt); else pass_cnt++;
    chk_cnt++; if (bus.RdPtr !== 14'd100) $display("FAIL bad_len1519_rdptr: got %0d want 100", bus.RdPtr); else pass_cnt++;
    chk_cnt++; if (burst_q.size() !== 1) $display("FAIL bad_no_tx: got %0d bursts want 1", burst_q.size()); else pass_cnt++;
    check_stream("bad_good_frame");
    chk_cnt++; if ((rd_done_q.size() > 0 ? rd_done_q[0] : 14'd0) !== 14'd10) $display("FAIL bad_rdptr_frame: got %0d want 10", rd_done_q.size() > 0 ? rd_done_q[0] : 14'd0); else pass_cnt++;
  endtask

  task automatic test_min_max();
    do_reset();
    put_frame(0, 1, 8'h7E, 8'h01, 16'h0000);
    put_frame(2, MAX_LEN, 8'h00, 8'h01, 16'hF800);
    bus.WrPtr = 14'd762; bus.Enable = 1'b1;
    wait_done(2, 2000);
    step(IFG + 4);
    chk_cnt++; if (done_cnt !== 2) $display("FAIL minmax_done: got %0d want 2", done_cnt); else pass_cnt++;
    chk_cnt++; if ((burst_q.size() > 0 ? burst_q[0] : -1) !== 9) $display("FAIL min_burst: got %0d want 9", burst_q.size() > 0 ? burst_q[0] : -1); else pass_cnt++;
    chk_cnt++; if ((burst_q.size() > 1 ? burst_q[1] : -1) !== 8 + MAX_LEN) $display("FAIL max_burst: got %0d want %0d", burst_q.size() > 1 ? burst_q[1] : -1, 8 + MAX_LEN); else pass_cnt++;
    chk_cnt++; if ((rd_done_q.size() > 0 ? rd_done_q[0] : 14'd0) !== 14'd2) $display("FAIL min_rdptr: got %0d want 2", rd_done_q.size() > 0 ? rd_done_q[0] : 14'd0); else pass_cnt++;
    chk_cnt++; if (bus.RdPtr !== 14'd762) $display("FAIL max_rdptr: got %0d want 762", bus.RdPtr); else pass_cnt++;
    chk_cnt++; if (err_cnt !== 0) $display("FAIL minmax_err: got %0d want 0", err_cnt); else pass_cnt++;
    check_stream("minmax");
  endtask

  task automatic test_reset_mid();
    int held;
    do_reset();
    put_frame(0, 100, 8'h3C, 8'h05, 16'h0000);
    bus.WrPtr = 14'd51; bus.Enable = 1'b1;
    for (int i = 0; i < 100; i++) begin
      if (rx_q.size() >= 28) break;
      step(1);
    end
    chk_cnt++; if (rx_q.size() < 28) $display("FAIL mid_reach: got %0d bytes want 28", rx_q.size()); else pass_cnt++;
    Reset = 1'b1;
    step(1);
    chk_cnt++; if (bus.TxEn !== 1'b0) $display("FAIL mid_txen: got %b want 0", bus.TxEn); else pass_cnt++;
    chk_cnt++; if (bus.RdPtr !== 14'd0) $display("FAIL mid_rdptr: got %0d want 0", bus.RdPtr); else pass_cnt++;
    chk_cnt++; if (bus.ClockEnB !== 1'b0) $display("FAIL mid_ce: got %b want 0", bus.ClockEnB); else pass_cnt++;
    held = rx_q.size();
    step(10);
    chk_cnt++; if (rx_q.size() !== held) $display("FAIL mid_quiet: got %0d bytes want %0d", rx_q.size(), held); else pass_cnt++;
    Reset = 1'b0;
    clear_mon();
    wait_done(1, 400);
    step(IFG + 4);
    chk_cnt++; if (done_cnt !== 1) $display("FAIL mid_resend_done: got %0d want 1", done_cnt); else pass_cnt++;
    check_stream("mid_resend");
    chk_cnt++; if (bus.RdPtr !== 14'd51) $display("FAIL mid_resend_rdptr: got %0d want 51", bus.RdPtr); else pass_cnt++;
  endtask

  initial begin
    Reset = 1'b1;
    bus.Enable = 1'b0;
    bus.WrPtr = '0;
    test_reset();
    test_empty();
    test_single();
    test_back_to_back();
    test_wrap();
    test_bad_headers();
    test_min_max();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
